// File: rtl/sfft_pkg.sv
// Shared definitions for the SFFT stream decoder: FSM state encoding and
// the count-width derivation used by the top, the lane counters and the bus.
package sfft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Width of the skip counter; the fill prefix is at most 255 cycles.
  localparam int SKIP_W = 8;

  // A window of 2**bitwidth bits can hold up to 2**bitwidth ones, which
  // needs one bit more than the window index.
  function automatic int calc_cw(input int bitwidth);
    return bitwidth + 1;
  endfunction

endpackage

// File: rtl/sfft_stream_decoder_if.sv
// Stream/result bus between the SFFT array, the decoder and its consumer.
// The master side drives streams and handshake; the decoder is the slave.
interface sfft_stream_decoder_if #(
  parameter int NUMINPUTS = 2,
  parameter int CW        = 9
);

  logic                    iEn;
  logic                    iClr;
  logic                    iStart;
  logic                    iReady;
  logic [NUMINPUTS-1:0]    iReal;
  logic [NUMINPUTS-1:0]    iImg;
  logic                    oBusy;
  logic                    oValid;
  logic [NUMINPUTS*CW-1:0] oReal;
  logic [NUMINPUTS*CW-1:0] oImg;

  modport master (
    output iEn, iClr, iStart, iReady, iReal, iImg,
    input  oBusy, oValid, oReal, oImg
  );

  modport slave (
    input  iEn, iClr, iStart, iReady, iReal, iImg,
    output oBusy, oValid, oReal, oImg
  );

endinterface

// File: rtl/sfft_ones_counter.sv
// One lane of the decoder: counts ones of a unary bitstream over a window.
module sfft_ones_counter #(
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [CW-1:0] count
);

  // Clear dominates; otherwise add the stream bit on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && bit_in) begin
      count <= count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/sfft_stream_decoder.sv
// Converts the real/imag unary output streams of the stochastic FFT back to
// binary ones counts over a 2**BITWIDTH enabled-cycle window, after dropping
// a SKIP-cycle fill prefix, and hands the result over with valid/ready.
module sfft_stream_decoder
  import sfft_pkg::*;
#(
  parameter int BITWIDTH  = 8,
  parameter int NUMINPUTS = 2,
  parameter int SKIP      = 0
) (
  input  logic                 iClk,
  input  logic                 iRst,
  sfft_stream_decoder_if.slave bus
);

  localparam int CW = calc_cw(BITWIDTH);
  localparam int NL = 2 * NUMINPUTS;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP == 0) ? 0 : SKIP - 1);

  state_t              state;
  logic [BITWIDTH-1:0] win_cnt;
  logic [SKIP_W-1:0]   skip_cnt;

  // Lanes 0..NUMINPUTS-1 are real, NUMINPUTS..NL-1 are imaginary.
  logic [NL-1:0] lane_bit;
  logic [CW-1:0] lane_cnt [NL];
  logic [CW-1:0] lane_sum [NL];
  logic          lane_clr;
  logic          lane_en;
  logic          last_bit;

  assign lane_bit = {bus.iImg, bus.iReal};

  // Counters are held at zero whenever no window is in progress, so both a
  // restart from DONE and a start from IDLE begin from a clean count.
  assign lane_clr = bus.iClr || (state == ST_IDLE) || (state == ST_DONE);
  assign lane_en  = (state == ST_RUN) && bus.iEn;
  assign last_bit = lane_en && (win_cnt == '1);

  for (genvar k = 0; k < NL; k++) begin : g_lane
    sfft_ones_counter #(.CW(CW)) u_cnt (
      .clk    (iClk),
      .rst    (iRst),
      .clr    (lane_clr),
      .en     (lane_en),
      .bit_in (lane_bit[k]),
      .count  (lane_cnt[k])
    );
    // The final bit is folded in here so the latched result includes it.
    assign lane_sum[k] = lane_cnt[k] + {{(CW-1){1'b0}}, lane_bit[k]};
  end

  // Control FSM with registered busy/valid and the result holding registers.
  always_ff @(posedge iClk) begin
    if (iRst || bus.iClr) begin
      state      <= ST_IDLE;
      win_cnt    <= '0;
      skip_cnt   <= '0;
      bus.oBusy  <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oReal  <= '0;
      bus.oImg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          win_cnt  <= '0;
          skip_cnt <= '0;
          if (bus.iStart) begin
            state     <= (SKIP > 0) ? ST_SKIP : ST_RUN;
            bus.oBusy <= 1'b1;
          end
        end
        ST_SKIP: begin
          if (bus.iEn) begin
            if (skip_cnt == SKIP_LAST) begin
              skip_cnt <= '0;
              state    <= ST_RUN;
            end else begin
              skip_cnt <= skip_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.iEn) begin
            win_cnt <= win_cnt + 1'b1;
            if (last_bit) begin
              state      <= ST_DONE;
              bus.oBusy  <= 1'b0;
              bus.oValid <= 1'b1;
              for (int k = 0; k < NUMINPUTS; k++) begin
                bus.oReal[k*CW +: CW] <= lane_sum[k];
                bus.oImg[k*CW +: CW]  <= lane_sum[NUMINPUTS + k];
              end
            end
          end
        end
        ST_DONE: begin
          win_cnt  <= '0;
          skip_cnt <= '0;
          if (bus.iReady) begin
            bus.oValid <= 1'b0;
            if (bus.iStart) begin
              state     <= (SKIP > 0) ? ST_SKIP : ST_RUN;
              bus.oBusy <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_stream_decoder.sv
// Directed bench for sfft_stream_decoder with BITWIDTH=4, NUMINPUTS=2.
// One instance with SKIP=0 carries most scenarios, a second with SKIP=3
// covers the fill-prefix case.
module tb_sfft_stream_decoder;

  localparam int BW = 4;
  localparam int NI = 2;
  localparam int CW = BW + 1;

  logic iClk;
  logic iRst;

  int n_chk;
  int n_err;

  sfft_stream_decoder_if #(.NUMINPUTS(NI), .CW(CW)) bus0 ();
  sfft_stream_decoder_if #(.NUMINPUTS(NI), .CW(CW)) bus3 ();

  sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI), .SKIP(0)) dut0 (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus0)
  );

  sfft_stream_decoder #(.BITWIDTH(BW), .NUMINPUTS(NI), .SKIP(3)) dut3 (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus3)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    iRst  = 1'b1;
    bus0.iEn = 1'b0; bus0.iClr = 1'b0; bus0.iStart = 1'b0; bus0.iReady = 1'b0;
    bus0.iReal = '0; bus0.iImg = '0;
    bus3.iEn = 1'b0; bus3.iClr = 1'b0; bus3.iStart = 1'b0; bus3.iReady = 1'b0;
    bus3.iReal = '0; bus3.iImg = '0;
    tick();
    tick();
    iRst = 1'b0;

    // Reset state
    check("rst_busy",  bus0.oBusy,  0);
    check("rst_valid", bus0.oValid, 0);
    check("rst_real",  bus0.oReal,  0);
    check("rst_img",   bus0.oImg,   0);

    // Constant streams: real lane0 and imag lane1 always 1
    bus0.iEn = 1'b1; bus0.iReal = 2'b01; bus0.iImg = 2'b10;
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    check("c_busy", bus0.oBusy, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("c_valid_early", bus0.oValid, 0);
    end
    check("c_valid", bus0.oValid, 1);
    check("c_busy_done", bus0.oBusy, 0);
    check("c_real", bus0.oReal, {5'd0, 5'd16});
    check("c_img",  bus0.oImg,  {5'd16, 5'd0});
    bus0.iReady = 1'b1;
    tick();
    bus0.iReady = 1'b0;
    check("c_valid_drop", bus0.oValid, 0);
    check("c_idle_busy",  bus0.oBusy,  0);
    check("c_hold_real",  bus0.oReal,  {5'd0, 5'd16});

    // Alternating lane0 with every 3rd cycle stalled; lane0 is 1 on stalls
    // and imag lanes stay 1, so any sampling during a stall shows up.
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    bus0.iImg = 2'b11;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 23; c++) begin
        bus0.iEn = (c % 3) != 2;
        bus0.iReal = bus0.iEn ? {1'b0, (k % 2) == 0} : 2'b01;
        if (bus0.iEn) k++;
        tick();
        if (c == 21) check("a_valid_early", bus0.oValid, 0);
      end
    end
    check("a_valid", bus0.oValid, 1);
    check("a_real", bus0.oReal, {5'd0, 5'd8});
    check("a_img",  bus0.oImg,  {5'd16, 5'd16});

    // Back-pressure: streams and iStart churn while the consumer is stalled
    for (int i = 0; i < 10; i++) begin
      bus0.iEn    = i[0];
      bus0.iStart = i[1];
      bus0.iReal  = 2'(i);
      bus0.iImg   = 2'(i + 1);
      tick();
      check("bp_valid", bus0.oValid, 1);
      check("bp_real",  bus0.oReal, {5'd0, 5'd8});
    end
    check("bp_img", bus0.oImg, {5'd16, 5'd16});

    // Accept and restart in the same cycle
    bus0.iEn = 1'b1; bus0.iReal = 2'b11; bus0.iImg = 2'b00;
    bus0.iReady = 1'b1; bus0.iStart = 1'b1;
    tick();
    bus0.iReady = 1'b0; bus0.iStart = 1'b0;
    check("rs_valid", bus0.oValid, 0);
    check("rs_busy",  bus0.oBusy,  1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("rs_valid_early", bus0.oValid, 0);
    end
    check("rs_valid_done", bus0.oValid, 1);
    check("rs_real", bus0.oReal, {5'd16, 5'd16});
    check("rs_img",  bus0.oImg,  {5'd0, 5'd0});
    bus0.iReady = 1'b1;
    tick();
    bus0.iReady = 1'b0;

    // SKIP=3: three leading ones are discarded, then 5 ones in the window;
    // an iStart pulse mid-window must not restart the conversion.
    bus3.iEn = 1'b1;
    bus3.iStart = 1'b1;
    tick();
    bus3.iStart = 1'b0;
    check("s_busy", bus3.oBusy, 1);
    for (int e = 0; e < 19; e++) begin
      bus3.iReal  = {1'b0, e < 8};
      bus3.iStart = (e == 6);
      tick();
      if (e == 17) check("s_valid_early", bus3.oValid, 0);
    end
    bus3.iStart = 1'b0;
    check("s_valid", bus3.oValid, 1);
    check("s_real",  bus3.oReal, {5'd0, 5'd5});
    check("s_img",   bus3.oImg,  0);
    bus3.iReady = 1'b1;
    tick();
    bus3.iReady = 1'b0;
    check("s_idle_valid", bus3.oValid, 0);
    check("s_idle_busy",  bus3.oBusy,  0);

    // Abort at window cycle 7
    bus0.iEn = 1'b1; bus0.iReal = 2'b11; bus0.iImg = 2'b01;
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    bus0.iClr = 1'b1;
    tick();
    bus0.iClr = 1'b0;
    check("ab_busy",  bus0.oBusy,  0);
    check("ab_valid", bus0.oValid, 0);
    check("ab_real",  bus0.oReal,  0);
    check("ab_img",   bus0.oImg,   0);

    // Fresh window after abort starts from zero counts
    bus0.iReal = 2'b10; bus0.iImg = 2'b11;
    bus0.iStart = 1'b1;
    tick();
    bus0.iStart = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("fr_valid_early", bus0.oValid, 0);
    end
    check("fr_valid", bus0.oValid, 1);
    check("fr_real",  bus0.oReal, {5'd16, 5'd0});
    check("fr_img",   bus0.oImg,  {5'd16, 5'd16});

    // Reset while holding a result
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check("rd_valid", bus0.oValid, 0);
    check("rd_busy",  bus0.oBusy,  0);
    check("rd_real",  bus0.oReal,  0);
    check("rd_img",   bus0.oImg,   0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
